// File: rtl/reg_write_scheduler.sv
// Round-robin write scheduler: picks one requester per cycle and drives a one-hot
// registered write enable plus a shared data bus into a bank of plain registers.
module reg_write_scheduler #(
    parameter int NUM_REQ  = 3,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       stall,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REGS-1:0]        write_enb,
    output logic [DATA_W-1:0]          C_in,
    output logic [2:0]                 last_grant,
    output logic                       err_out,
    input  logic                       err_clr
);

    logic [2:0]            rr_ptr_reg;
    logic [2:0]            rr_ptr_next;
    logic [2*NUM_REQ-1:0]  dbl_valid;
    logic [NUM_REQ-1:0]    rot_valid;
    logic                  found;
    logic [2:0]            winner;
    logic [NUM_REQ-1:0]    grant;
    logic                  accept;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic                  in_range;
    logic [NUM_REGS-1:0]   addr_onehot;
    logic [NUM_REGS-1:0]   write_enb_next;
    logic [DATA_W-1:0]     c_in_next;
    logic [2:0]            last_grant_next;
    logic                  err_next;

    // Rotating the doubled request vector puts rr_ptr at bit 0, so the first set
    // bit is the round-robin winner expressed as an offset from the pointer.
    assign dbl_valid = {req_valid, req_valid};
    assign rot_valid = NUM_REQ'(dbl_valid >> rr_ptr_reg);

    always_comb begin
        int sum;
        found  = 1'b0;
        winner = '0;
        sum    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot_valid[k]) begin
                found = 1'b1;
                sum   = int'(rr_ptr_reg) + k;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                winner = 3'(sum);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = found && !stall && (winner == 3'(gi));
        end
    endgenerate

    assign req_ready = grant;
    assign accept    = |grant;

    // Grant is one-hot, so an AND-OR mux selects the winner's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_addr = req_addr[k*ADDR_W +: ADDR_W];
                sel_data = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign in_range = (int'(sel_addr) < NUM_REGS);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_onehot
            assign addr_onehot[gi] = (sel_addr == ADDR_W'(gi));
        end
    endgenerate

    always_comb begin
        write_enb_next  = '0;
        c_in_next       = C_in;
        last_grant_next = last_grant;
        rr_ptr_next     = rr_ptr_reg;
        err_next        = err_clr ? 1'b0 : err_out;
        if (accept) begin
            last_grant_next = winner;
            rr_ptr_next     = (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;
            if (in_range) begin
                write_enb_next = addr_onehot;
                c_in_next      = sel_data;
            end else begin
                // A bad address is still consumed; setting the flag beats a clear.
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            write_enb  <= '0;
            C_in       <= '0;
            last_grant <= '0;
            err_out    <= 1'b0;
            rr_ptr_reg <= '0;
        end else begin
            write_enb  <= write_enb_next;
            C_in       <= c_in_next;
            last_grant <= last_grant_next;
            err_out    <= err_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Bench for reg_write_scheduler: directed table, hand-written corner sequences,
// randomized traffic against a queue-free arithmetic reference model.
module tb_reg_write_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        stall;
    logic        err_clr;
    logic [2:0]  req_valid;
    logic [5:0]  req_addr;
    logic [23:0] req_data;
    logic [2:0]  req_ready;
    logic [3:0]  write_enb;
    logic [7:0]  c_in;
    logic [2:0]  last_grant;
    logic        err_out;

    logic        e_stall;
    logic        e_err_clr;
    logic [2:0]  e_valid;
    logic [5:0]  e_addr;
    logic [23:0] e_data;
    logic [2:0]  e_ready;
    logic [2:0]  e_we;
    logic [7:0]  e_cin;
    logic [2:0]  e_last;
    logic        e_err;

    reg_write_scheduler dut (
        .clk(clk), .rstn(rstn), .stall(stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .write_enb(write_enb), .C_in(c_in),
        .last_grant(last_grant), .err_out(err_out), .err_clr(err_clr)
    );

    reg_write_scheduler #(.NUM_REQ(3), .NUM_REGS(3), .ADDR_W(2), .DATA_W(8)) dut_e (
        .clk(clk), .rstn(rstn), .stall(e_stall),
        .req_valid(e_valid), .req_addr(e_addr), .req_data(e_data),
        .req_ready(e_ready), .write_enb(e_we), .C_in(e_cin),
        .last_grant(e_last), .err_out(e_err), .err_clr(e_err_clr)
    );

    // Model of the downstream register bank fed by the scheduler.
    logic [7:0] bank [4];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (write_enb[i]) bank[i] <= c_in;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic [2:0]  valid;
        logic [5:0]  addr;
        logic [23:0] data;
        logic [2:0]  exp_ready;
        logic [3:0]  exp_we;
        logic [7:0]  exp_cin;
        logic [2:0]  exp_last;
    } vec_t;

    vec_t vecs [14];

    int         m_ptr;
    int         w;
    logic [3:0] m_we;
    logic [7:0] m_cin;
    logic [2:0] m_last;
    logic [2:0] m_acc;
    logic [2:0] exp_ready;
    int         accepts;

    initial begin
        // Round-robin sweep, stall window, then a same-address conflict.
        vecs[0]  = '{1'b0, 3'b111, 6'h24, 24'h332211, 3'b001, 4'b0000, 8'h00, 3'd0};
        vecs[1]  = '{1'b0, 3'b111, 6'h24, 24'h332211, 3'b010, 4'b0001, 8'h11, 3'd0};
        vecs[2]  = '{1'b0, 3'b111, 6'h24, 24'h332211, 3'b100, 4'b0010, 8'h22, 3'd1};
        vecs[3]  = '{1'b0, 3'b111, 6'h24, 24'h332211, 3'b001, 4'b0100, 8'h33, 3'd2};
        vecs[4]  = '{1'b0, 3'b111, 6'h24, 24'h332211, 3'b010, 4'b0001, 8'h11, 3'd0};
        vecs[5]  = '{1'b0, 3'b111, 6'h24, 24'h332211, 3'b100, 4'b0010, 8'h22, 3'd1};
        vecs[6]  = '{1'b1, 3'b001, 6'h24, 24'h332211, 3'b000, 4'b0100, 8'h33, 3'd2};
        vecs[7]  = '{1'b1, 3'b001, 6'h24, 24'h332211, 3'b000, 4'b0000, 8'h33, 3'd2};
        vecs[8]  = '{1'b1, 3'b001, 6'h24, 24'h332211, 3'b000, 4'b0000, 8'h33, 3'd2};
        vecs[9]  = '{1'b0, 3'b001, 6'h24, 24'h332211, 3'b001, 4'b0000, 8'h33, 3'd2};
        vecs[10] = '{1'b0, 3'b110, 6'h3C, 24'hC33C11, 3'b010, 4'b0001, 8'h11, 3'd0};
        vecs[11] = '{1'b0, 3'b100, 6'h3C, 24'hC33C11, 3'b100, 4'b1000, 8'h3C, 3'd1};
        vecs[12] = '{1'b0, 3'b000, 6'h3C, 24'hC33C11, 3'b000, 4'b1000, 8'hC3, 3'd2};
        vecs[13] = '{1'b0, 3'b000, 6'h3C, 24'hC33C11, 3'b000, 4'b0000, 8'hC3, 3'd2};

        rstn = 1'b0; stall = 1'b0; err_clr = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
        e_stall = 1'b0; e_err_clr = 1'b0; e_valid = '0; e_addr = '0; e_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_we", 32'(write_enb), 32'h0);
        chk("reset_cin", 32'(c_in), 32'h0);
        chk("reset_last", 32'(last_grant), 32'h0);
        chk("reset_err", 32'(err_out), 32'h0);
        chk("reset_err_e", 32'(e_err), 32'h0);
        $display("reset state checked");
        @(negedge clk);
        rstn = 1'b1;

        // Single write, then async reset in the middle of the pulse
        @(negedge clk);
        req_valid = 3'b001; req_addr = 6'h02; req_data = 24'h0000A5;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        chk("single_we", 32'(write_enb), 32'h4);
        chk("single_cin", 32'(c_in), 32'hA5);
        $display("single write: we=%b C_in=%h", write_enb, c_in);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_we", 32'(write_enb), 32'h0);
        chk("async_rst_cin", 32'(c_in), 32'h0);
        chk("async_rst_err", 32'(err_out), 32'h0);
        $display("async reset mid-pulse: we=%b C_in=%h", write_enb, c_in);
        @(negedge clk);
        rstn = 1'b1;

        // Directed table
        for (int r = 0; r < 14; r++) begin
            @(negedge clk);
            stall     = vecs[r].stall;
            req_valid = vecs[r].valid;
            req_addr  = vecs[r].addr;
            req_data  = vecs[r].data;
            #1;
            chk($sformatf("row%0d_ready", r), 32'(req_ready), 32'(vecs[r].exp_ready));
            chk($sformatf("row%0d_we", r), 32'(write_enb), 32'(vecs[r].exp_we));
            chk($sformatf("row%0d_cin", r), 32'(c_in), 32'(vecs[r].exp_cin));
            chk($sformatf("row%0d_last", r), 32'(last_grant), 32'(vecs[r].exp_last));
            chk($sformatf("row%0d_err", r), 32'(err_out), 32'h0);
            $display("row %0d: stall=%b valid=%b ready=%b we=%b C_in=%h last=%0d",
                     r, stall, req_valid, req_ready, write_enb, c_in, last_grant);
        end
        chk("conflict_reg3", 32'(bank[3]), 32'hC3);

        // Randomized traffic against the reference model
        @(negedge clk);
        rstn = 1'b0; stall = 1'b0; req_valid = '0;
        #1;
        rstn = 1'b1;
        m_ptr = 0; m_we = '0; m_cin = '0; m_last = '0; m_acc = '0; accepts = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (m_acc[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        req_valid[i]       = 1'b1;
                        req_addr[i*2 +: 2] = 2'($urandom_range(0, 3));
                        req_data[i*8 +: 8] = 8'($urandom);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            stall = ($urandom_range(0, 3) == 0);
            w = -1;
            for (int k = 0; k < 3; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
            end
            if (stall) w = -1;
            exp_ready = (w >= 0) ? 3'(1 << w) : 3'b000;
            #1;
            chk("rand_ready", 32'(req_ready), 32'(exp_ready));
            chk("rand_we", 32'(write_enb), 32'(m_we));
            chk("rand_cin", 32'(c_in), 32'(m_cin));
            chk("rand_last", 32'(last_grant), 32'(m_last));
            if (w >= 0) begin
                m_we   = 4'(1 << req_addr[w*2 +: 2]);
                m_cin  = req_data[w*8 +: 8];
                m_last = 3'(w);
                m_ptr  = (w + 1) % 3;
                m_acc  = exp_ready;
                accepts++;
            end else begin
                m_we  = '0;
                m_acc = '0;
            end
        end
        stall = 1'b0; req_valid = '0;
        $display("random phase: 400 cycles, %0d accepts", accepts);

        // Error path on the NUM_REGS=3 instance
        @(negedge clk);
        e_valid = 3'b001; e_addr = 6'h01; e_data = 24'h00005A;
        #1;
        chk("err_good_ready", 32'(e_ready), 32'h1);
        @(negedge clk);
        e_addr = 6'h03; e_data = 24'h0000FF;
        #1;
        chk("err_bad_ready", 32'(e_ready), 32'h1);
        chk("err_good_we", 32'(e_we), 32'h2);
        chk("err_good_cin", 32'(e_cin), 32'h5A);
        chk("err_before", 32'(e_err), 32'h0);
        @(negedge clk);
        e_valid = 3'b000;
        #1;
        chk("err_bad_we", 32'(e_we), 32'h0);
        chk("err_bad_cin", 32'(e_cin), 32'h5A);
        chk("err_set", 32'(e_err), 32'h1);
        chk("err_bad_last", 32'(e_last), 32'h0);
        $display("bad address: we=%b C_in=%h err=%b", e_we, e_cin, e_err);
        @(negedge clk);
        #1;
        chk("err_sticky", 32'(e_err), 32'h1);
        @(negedge clk);
        e_err_clr = 1'b1;
        @(negedge clk);
        e_err_clr = 1'b0;
        #1;
        chk("err_cleared", 32'(e_err), 32'h0);
        $display("err_clr alone: err=%b", e_err);
        @(negedge clk);
        e_err_clr = 1'b1; e_valid = 3'b001;
        #1;
        chk("err_clr_set_ready", 32'(e_ready), 32'h1);
        @(negedge clk);
        e_err_clr = 1'b0; e_valid = 3'b000;
        #1;
        chk("err_set_wins", 32'(e_err), 32'h1);
        chk("err_set_wins_we", 32'(e_we), 32'h0);
        chk("err_set_wins_cin", 32'(e_cin), 32'h5A);
        $display("err_clr with new error: err=%b", e_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
